// File: rtl/gaussian_output_packer.sv
// Packs the gaussian accelerator's pixel stream into LANES-wide words queued for a valid/ready sink.
// Optional statistics outputs (stall_cycles, drop_count) exist only when PACKER_STATS_EN is defined.
module gaussian_output_packer #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned LANES      = 4,
   parameter int unsigned IMG_W      = 64,
   parameter int unsigned IMG_H      = 64,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic                             in_valid,
   input  logic [DATA_W-1:0]                in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_W*LANES-1:0]          out_data,
   output logic                             out_last,
   output logic                             frame_done,
   output logic                             overflow,
`ifdef PACKER_STATS_EN
   output logic [31:0]                      stall_cycles,
   output logic [15:0]                      drop_count,
`endif
   output logic [$clog2(IMG_W*IMG_H+1)-1:0] pixel_count
);

   localparam int unsigned WORD_W = DATA_W * LANES;
   localparam int unsigned LANE_W = $clog2(LANES);
   localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned PC_W   = $clog2(IMG_W * IMG_H + 1);
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);

   logic [LANE_W-1:0] lane_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [PC_W-1:0]   pix_q;
   logic [WORD_W-1:0] part_q;
   logic              frame_done_q;
   logic              overflow_q;

   logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_mem_q;
   logic [AW:0]           wr_q;
   logic [AW:0]           rd_q;

   logic              clear;
   logic              col_end;
   logic              last_px;
   logic              word_done;
   logic [WORD_W-1:0] word_next;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push_ok;
   logic              drop;

   assign clear     = rst | flush;
   assign col_end   = (col_q == COL_W'(IMG_W - 1));
   assign last_px   = in_valid && col_end && (row_q == ROW_W'(IMG_H - 1));
   assign word_done = in_valid && ((lane_q == LANE_W'(LANES - 1)) || last_px);

   // Lanes above lane_q are still zero in part_q, so a short final word comes out zero-padded.
   always_comb begin
      word_next = part_q;
      for (int l = 0; l < LANES; l++) begin
         if (lane_q == LANE_W'(l)) word_next[l*DATA_W +: DATA_W] = in_data;
      end
   end

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop     = !empty && out_ready;
   assign push_ok = word_done && (!full || pop);
   assign drop    = word_done && full && !pop;

   always_ff @(posedge clk) begin
      if (clear) begin
         lane_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         pix_q        <= '0;
         part_q       <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         wr_q         <= '0;
         rd_q         <= '0;
      end else begin
         frame_done_q <= last_px;
         if (in_valid) begin
            if (word_done) begin
               lane_q <= '0;
               part_q <= '0;
            end else begin
               lane_q <= lane_q + 1'b1;
               part_q <= word_next;
            end
            if (last_px) begin
               col_q <= '0;
               row_q <= '0;
               pix_q <= '0;
            end else begin
               pix_q <= pix_q + 1'b1;
               if (col_end) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
         end
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         if (drop) overflow_q <= 1'b1;
      end
   end

   // A full FIFO with a simultaneous pop writes into the slot being read this cycle; the read
   // sees the old word and the new one becomes the tail after the pointers move.
   always_ff @(posedge clk) begin
      if (!clear && push_ok) begin
         mem_q[wr_q[AW-1:0]]      <= word_next;
         last_mem_q[wr_q[AW-1:0]] <= last_px;
      end
   end

   assign out_valid   = !empty;
   assign out_data    = empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign out_last    = !empty && last_mem_q[rd_q[AW-1:0]];
   assign frame_done  = frame_done_q;
   assign overflow    = overflow_q;
   assign pixel_count = pix_q;

`ifdef PACKER_STATS_EN
   logic [31:0] stall_q;
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         stall_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign drop_count   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_gaussian_output_packer.sv
// Randomized bench for gaussian_output_packer against a queue-based frame/FIFO reference model.
module tb_gaussian_output_packer;

   localparam int unsigned DW   = 16;
   localparam int unsigned LN   = 4;
   localparam int unsigned IW   = 4;
   localparam int unsigned IH   = 2;
   localparam int unsigned FD   = 2;
   localparam int unsigned NPIX = IW * IH;
   localparam int unsigned WW   = DW * LN;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [WW-1:0] out_data;
   logic          out_last;
   logic          frame_done;
   logic          overflow;
   logic [3:0]    pixel_count;

   logic          pad_in_valid = 1'b0;
   logic [DW-1:0] pad_in_data = '0;
   logic          pad_ready = 1'b1;
   logic          pad_out_valid;
   logic [WW-1:0] pad_out_data;
   logic          pad_out_last;
   logic          pad_frame_done;
   logic          pad_overflow;
   logic [2:0]    pad_pixel_count;

`ifdef PACKER_STATS_EN
   logic [31:0] stall_cycles, pad_stall_cycles;
   logic [15:0] drop_count, pad_drop_count;
`endif

   always #5 clk = ~clk;

   gaussian_output_packer #(
      .DATA_W(DW), .LANES(LN), .IMG_W(IW), .IMG_H(IH), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .frame_done(frame_done), .overflow(overflow),
`ifdef PACKER_STATS_EN
      .stall_cycles(stall_cycles), .drop_count(drop_count),
`endif
      .pixel_count(pixel_count)
   );

   gaussian_output_packer #(
      .DATA_W(DW), .LANES(LN), .IMG_W(3), .IMG_H(2), .FIFO_DEPTH(4)
   ) dut_pad (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(pad_in_valid), .in_data(pad_in_data),
      .out_valid(pad_out_valid), .out_ready(pad_ready), .out_data(pad_out_data),
      .out_last(pad_out_last), .frame_done(pad_frame_done), .overflow(pad_overflow),
`ifdef PACKER_STATS_EN
      .stall_cycles(pad_stall_cycles), .drop_count(pad_drop_count),
`endif
      .pixel_count(pad_pixel_count)
   );

   // Reference model: words are {last, data}; q_exp is the sink-visible queue.
   logic [WW:0]   q_exp[$];
   logic [WW:0]   popped[$];
   logic [WW:0]   got[$];
   logic [DW-1:0] cur_px[LN];
   int            cur_n = 0;
   int            m_pix = 0;
   int            m_drops = 0;
   bit            m_ovf = 1'b0;
   int            fd_seen = 0;
   int            n_cmp = 0;
   int            n_fail = 0;

   // One clock cycle: drive inputs, record words the DUT hands over, advance the model.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
      bit          full, pop, last;
      logic [WW-1:0] w;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      flush     = fl;
      if (!rst && !fl && out_valid === 1'b1 && rdy) got.push_back({out_last, out_data});
      if (rst || fl) begin
         q_exp.delete();
         cur_n = 0;
         m_pix = 0;
         m_ovf = 1'b0;
         m_drops = 0;
      end else begin
         full = (q_exp.size() == FD);
         pop  = (q_exp.size() > 0) && rdy;
         if (pop) begin
            popped.push_back(q_exp[0]);
            void'(q_exp.pop_front());
         end
         if (v) begin
            cur_px[cur_n] = d;
            cur_n++;
            m_pix++;
            last = (m_pix == NPIX);
            if (cur_n == LN || last) begin
               w = '0;
               for (int i = 0; i < cur_n; i++) w[i*DW +: DW] = cur_px[i];
               if (!full || pop) q_exp.push_back({last, w});
               else begin
                  m_ovf = 1'b1;
                  m_drops++;
               end
               cur_n = 0;
            end
            if (last) m_pix = 0;
         end
      end
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_seen++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      n_cmp += 6;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
      if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      if (pixel_count !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pixel_count); end
      step(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [WW:0] exp_w[2];
      logic [WW:0] act;
      int fd0;
      got.delete(); popped.delete();
      fd0 = fd_seen;
      exp_w[0] = {1'b0, 64'h0004_0003_0002_0001};
      exp_w[1] = {1'b1, 64'h0008_0007_0006_0005};
      for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (got.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d words want 2", got.size()); end
      for (int i = 0; i < 2; i++) begin
         act = (i < got.size()) ? got[i] : 'x;
         n_cmp++;
         if (act !== exp_w[i]) begin
            n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, act, exp_w[i]);
         end
      end
      n_cmp += 2;
      if (fd_seen - fd0 != 1) begin n_fail++; $display("FAIL basic_fd: got %0d pulses want 1", fd_seen - fd0); end
      if (pixel_count !== 4'd0) begin n_fail++; $display("FAIL basic_pc: got %0d want 0", pixel_count); end
   endtask

   task automatic test_padding();
      logic [WW:0] exp_w[2];
      logic [WW:0] pad_got[$];
      logic [WW:0] act;
      int fds;
      fds = 0;
      exp_w[0] = {1'b0, 64'h0013_0012_0011_0010};
      exp_w[1] = {1'b1, 64'h0000_0000_0015_0014};
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (pad_out_valid === 1'b1) pad_got.push_back({pad_out_last, pad_out_data});
         if (pad_frame_done === 1'b1) fds++;
         pad_in_valid = (i < 6);
         pad_in_data  = DW'(16'h10 + i);
      end
      n_cmp++;
      if (pad_got.size() != 2) begin n_fail++; $display("FAIL pad_count: got %0d words want 2", pad_got.size()); end
      for (int i = 0; i < 2; i++) begin
         act = (i < pad_got.size()) ? pad_got[i] : 'x;
         n_cmp++;
         if (act !== exp_w[i]) begin
            n_fail++; $display("FAIL pad_word%0d: got %h want %h", i, act, exp_w[i]);
         end
      end
      n_cmp += 2;
      if (fds != 1) begin n_fail++; $display("FAIL pad_fd: got %0d pulses want 1", fds); end
      if (pad_pixel_count !== 3'd0) begin n_fail++; $display("FAIL pad_pc: got %0d want 0", pad_pixel_count); end
   endtask

   task automatic test_overflow();
      logic [WW:0] act;
      step(1'b0, '0, 1'b0, 1'b1);
      got.delete(); popped.delete();
      for (int i = 0; i < 12; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      n_cmp += 5;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      if (pixel_count !== 4'(m_pix)) begin n_fail++; $display("FAIL ovf_pc: got %0d want %0d", pixel_count, m_pix); end
      if (out_data !== q_exp[0][WW-1:0]) begin
         n_fail++; $display("FAIL ovf_hold_data: got %h want %h", out_data, q_exp[0][WW-1:0]);
      end
      if (out_last !== q_exp[0][WW]) begin n_fail++; $display("FAIL ovf_hold_last: got %b want %b", out_last, q_exp[0][WW]); end
`ifdef PACKER_STATS_EN
      n_cmp++;
      if (drop_count !== 16'(m_drops)) begin n_fail++; $display("FAIL ovf_drops: got %0d want %0d", drop_count, m_drops); end
`endif
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_cmp += 3;
      if (got.size() != 2) begin n_fail++; $display("FAIL ovf_drain: got %0d words want 2", got.size()); end
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
      foreach (popped[i]) begin
         act = (i < got.size()) ? got[i] : 'x;
         n_cmp++;
         if (act !== popped[i]) begin n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, act, popped[i]); end
      end
   endtask

   task automatic test_full_pop();
      logic [WW:0] act;
      step(1'b0, '0, 1'b0, 1'b1);
      got.delete(); popped.delete();
      for (int i = 0; i < 11; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      n_cmp += 2;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fullpop_valid: got %b want 1", out_valid); end
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (got.size() != 3) begin n_fail++; $display("FAIL fullpop_count: got %0d words want 3", got.size()); end
      foreach (popped[i]) begin
         act = (i < got.size()) ? got[i] : 'x;
         n_cmp++;
         if (act !== popped[i]) begin n_fail++; $display("FAIL fullpop_word%0d: got %h want %h", i, act, popped[i]); end
      end
   endtask

   task automatic test_flush();
      logic [DW-1:0] d[4];
      logic [WW:0]   exp_w;
      logic [WW:0]   act;
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 14; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      n_cmp += 3;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", overflow); end
      if (pixel_count !== 4'd0) begin n_fail++; $display("FAIL flush_pc: got %0d want 0", pixel_count); end
      got.delete(); popped.delete();
      for (int i = 0; i < 4; i++) begin
         d[i] = DW'($urandom);
         step(1'b1, d[i], 1'b1, 1'b0);
      end
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      exp_w = {1'b0, d[3], d[2], d[1], d[0]};
      act = (got.size() > 0) ? got[0] : 'x;
      n_cmp += 2;
      if (got.size() != 1) begin n_fail++; $display("FAIL flush_count: got %0d words want 1", got.size()); end
      if (act !== exp_w) begin n_fail++; $display("FAIL flush_word: got %h want %h", act, exp_w); end
   endtask

   task automatic test_back_to_back();
      logic [WW:0] act;
      int fd0;
      step(1'b0, '0, 1'b1, 1'b1);
      got.delete(); popped.delete();
      fd0 = fd_seen;
      for (int k = 0; k < 2 * 2 * NPIX; k++)
         step((k % 2) == 0, DW'($urandom), $urandom_range(0, 3) != 0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_cmp += 4;
      if (got.size() != popped.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d words want %0d", got.size(), popped.size());
      end
      if (fd_seen - fd0 != 2) begin n_fail++; $display("FAIL b2b_fd: got %0d pulses want 2", fd_seen - fd0); end
      if (overflow !== m_ovf) begin n_fail++; $display("FAIL b2b_ovf: got %b want %b", overflow, m_ovf); end
      if (pixel_count !== 4'd0) begin n_fail++; $display("FAIL b2b_pc: got %0d want 0", pixel_count); end
      foreach (popped[i]) begin
         act = (i < got.size()) ? got[i] : 'x;
         n_cmp++;
         if (act !== popped[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, act, popped[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_padding();
      test_overflow();
      test_full_pop();
      test_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
